// File: rtl/rgb_led_monitor.sv
// rgb_led_monitor
//   Watches three active-low RGB LED drive pins, debounces the decoded color
//   code and reports each qualified color change.  It measures the dwell
//   time between changes and latches sticky flags for out-of-order colors
//   and out-of-tolerance dwell times.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   RGB_R/G/B    active-low LED drive pins (0 = lit), asynchronous to clk
//   clr_err      synchronous clear of seq_err / dwell_err
//   color_idx    qualified color code (0 red .. 5 magenta, 6 off, 7 white)
//   color_valid  at least one code has qualified since reset
//   change_pulse one-cycle strobe on each qualified code change
//   dwell_out    cycles between the last two change pulses (saturating)
//   seq_err      sticky illegal-transition flag
//   dwell_err    sticky out-of-tolerance dwell flag
module rgb_led_monitor #(
   parameter int STABLE_CYCLES  = 4,
   parameter int DWELL_W        = 24,
   parameter int EXPECTED_DWELL = 2000000,
   parameter int DWELL_TOL      = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               RGB_R,
   input  logic               RGB_G,
   input  logic               RGB_B,
   input  logic               clr_err,
   output logic [2:0]         color_idx,
   output logic               color_valid,
   output logic               change_pulse,
   output logic [DWELL_W-1:0] dwell_out,
   output logic               seq_err,
   output logic               dwell_err
);

   localparam logic [7:0]         QUAL_CNT = 8'(STABLE_CYCLES - 1);
   localparam logic [DWELL_W-1:0] DW_ONE   = {{(DWELL_W-1){1'b0}}, 1'b1};
   localparam longint             DW_LO    = longint'(EXPECTED_DWELL) - longint'(DWELL_TOL);
   localparam longint             DW_HI    = longint'(EXPECTED_DWELL) + longint'(DWELL_TOL);

   // Two-flop synchronizer, bit order {R,G,B}
   logic [2:0] r_sync1, r_sync2;
   logic [2:0] w_lit;
   logic [2:0] w_code;

   // Qualifier
   logic [2:0] r_cand;
   logic [7:0] r_cnt;
   logic [7:0] w_cnt_nxt;
   logic       r_qual;

   // Tracking
   logic [2:0]         r_color_idx;
   logic [2:0]         r_prev_idx;
   logic               r_color_valid;
   logic               r_change_pulse;
   logic [DWELL_W-1:0] r_dwell;
   logic [DWELL_W-1:0] r_dwell_out;
   logic               r_seen_pulse;
   logic               r_chk_dwell;
   logic               r_seq_err;
   logic               r_dwell_err;

   logic w_first;
   logic w_change;
   logic w_seq_bad;
   logic w_dwell_bad;
   logic [2:0] w_next_legal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 3'b000;
         r_sync2 <= 3'b000;
      end else begin
         r_sync1 <= {RGB_R, RGB_G, RGB_B};
         r_sync2 <= r_sync1;
      end
   end

   assign w_lit = ~r_sync2;

   always_comb begin
      w_code = 3'd6;
      case (w_lit)
         3'b100:  w_code = 3'd0;
         3'b110:  w_code = 3'd1;
         3'b010:  w_code = 3'd2;
         3'b011:  w_code = 3'd3;
         3'b001:  w_code = 3'd4;
         3'b101:  w_code = 3'd5;
         3'b000:  w_code = 3'd6;
         3'b111:  w_code = 3'd7;
         default: w_code = 3'd6;
      endcase
   end

   // The stability count passes QUAL_CNT exactly once per steady run of
   // the candidate (it saturates at 255, above any legal QUAL_CNT), so
   // r_qual is a single-cycle qualification event.
   assign w_cnt_nxt = (w_code != r_cand) ? 8'd0 :
                      ((r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cand <= 3'd0;
         r_cnt  <= 8'd0;
         r_qual <= 1'b0;
      end else begin
         r_cand <= w_code;
         r_cnt  <= w_cnt_nxt;
         r_qual <= (w_cnt_nxt == QUAL_CNT);
      end
   end

   // First qualification only arms the monitor; later ones matter only if
   // they bring a different code.
   assign w_first  = r_qual && !r_color_valid;
   assign w_change = r_qual && r_color_valid && (r_cand != r_color_idx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_color_idx    <= 3'd0;
         r_prev_idx     <= 3'd0;
         r_color_valid  <= 1'b0;
         r_change_pulse <= 1'b0;
         r_dwell        <= '0;
         r_dwell_out    <= '0;
         r_seen_pulse   <= 1'b0;
         r_chk_dwell    <= 1'b0;
      end else begin
         r_change_pulse <= w_change;
         if (w_first) begin
            r_color_valid <= 1'b1;
            r_color_idx   <= r_cand;
            r_dwell       <= DW_ONE;
         end else if (w_change) begin
            r_color_idx  <= r_cand;
            r_prev_idx   <= r_color_idx;
            // Current count equals the distance to the previous event
            r_dwell_out  <= r_dwell;
            r_dwell      <= DW_ONE;
            // The dwell ending at the first pulse is partial: skip its check
            r_chk_dwell  <= r_seen_pulse;
            r_seen_pulse <= 1'b1;
         end else if (r_color_valid && !(&r_dwell)) begin
            r_dwell <= r_dwell + DW_ONE;
         end
      end
   end

   // Checks run in the change_pulse cycle, using the old/new code pair
   assign w_next_legal = (r_prev_idx == 3'd5) ? 3'd0 : r_prev_idx + 3'd1;
   assign w_seq_bad    = (r_prev_idx > 3'd5) || (r_color_idx > 3'd5) ||
                         (r_color_idx != w_next_legal);
   assign w_dwell_bad  = r_chk_dwell &&
                         ((longint'(r_dwell_out) < DW_LO) || (longint'(r_dwell_out) > DW_HI));

   // Set has priority over clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seq_err   <= 1'b0;
         r_dwell_err <= 1'b0;
      end else begin
         if (r_change_pulse && w_seq_bad)
            r_seq_err <= 1'b1;
         else if (clr_err)
            r_seq_err <= 1'b0;
         if (r_change_pulse && w_dwell_bad)
            r_dwell_err <= 1'b1;
         else if (clr_err)
            r_dwell_err <= 1'b0;
      end
   end

   assign color_idx    = r_color_idx;
   assign color_valid  = r_color_valid;
   assign change_pulse = r_change_pulse;
   assign dwell_out    = r_dwell_out;
   assign seq_err      = r_seq_err;
   assign dwell_err    = r_dwell_err;

endmodule

// File: tb/tb_rgb_led_monitor.sv
// tb_rgb_led_monitor
//   Bench for rgb_led_monitor with STABLE_CYCLES=4, EXPECTED_DWELL=20,
//   DWELL_TOL=0, DWELL_W=8.  Pin codes are driven on the falling edge; every
//   steady code that should produce a change_pulse pushes its expected
//   cycle, color and dwell onto exp_q, and a monitor pops them as pulses
//   appear.
module tb_rgb_led_monitor;

  localparam int S   = 4;
  localparam int EXP = 20;
  localparam int TOL = 0;
  localparam int W   = 8;
  localparam int LAT = S + 3;  // drive negedge -> pulse observed at negedge

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pin_r = 1'b1;
  logic         pin_g = 1'b1;
  logic         pin_b = 1'b1;
  logic         clr_err = 1'b0;
  logic [2:0]   color_idx;
  logic         color_valid;
  logic         change_pulse;
  logic [W-1:0] dwell_out;
  logic         seq_err;
  logic         dwell_err;

  rgb_led_monitor #(
    .STABLE_CYCLES(S),
    .DWELL_W(W),
    .EXPECTED_DWELL(EXP),
    .DWELL_TOL(TOL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .RGB_R(pin_r),
    .RGB_G(pin_g),
    .RGB_B(pin_b),
    .clr_err(clr_err),
    .color_idx(color_idx),
    .color_valid(color_valid),
    .change_pulse(change_pulse),
    .dwell_out(dwell_out),
    .seq_err(seq_err),
    .dwell_err(dwell_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int           at;
    logic [2:0]   idx;
    logic [W-1:0] dwell;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  bit         m_valid = 1'b0;
  logic [2:0] m_idx   = 3'd0;
  int         m_last  = 0;

  // Lit pattern {R,G,B} per code; pins are its complement.
  function automatic logic [2:0] code_to_pins(input logic [2:0] c);
    logic [2:0] lit;
    case (c)
      3'd0:    lit = 3'b100;
      3'd1:    lit = 3'b110;
      3'd2:    lit = 3'b010;
      3'd3:    lit = 3'b011;
      3'd4:    lit = 3'b001;
      3'd5:    lit = 3'b101;
      3'd6:    lit = 3'b000;
      default: lit = 3'b111;
    endcase
    return ~lit;
  endfunction

  // Model of what a steady code driven at negedge cycle 'at' produces.
  task automatic model_code(input logic [2:0] c, input int at);
    exp_t e;
    int   d;
    if (!m_valid) begin
      m_valid = 1'b1;
      m_idx   = c;
      m_last  = at + LAT;
    end else if (c != m_idx) begin
      d = at + LAT - m_last;
      if (d > 255) d = 255;
      e.at    = at + LAT;
      e.idx   = c;
      e.dwell = W'(d);
      exp_q.push_back(e);
      m_idx  = c;
      m_last = at + LAT;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && change_pulse) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: change_pulse=1 idx=%0d at cycle %0d, required no pulse",
                 color_idx, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (cyc !== mon_e.at || color_idx !== mon_e.idx || dwell_out !== mon_e.dwell) begin
          n_fail++;
          $display("FAIL pulse: cycle=%0d idx=%0d dwell=%0d, required cycle=%0d idx=%0d dwell=%0d",
                   cyc, color_idx, dwell_out, mon_e.at, mon_e.idx, mon_e.dwell);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_code(input logic [2:0] c, input bit steady);
    @(negedge clk);
    {pin_r, pin_g, pin_b} = code_to_pins(c);
    if (steady) model_code(c, cyc);
  endtask

  task automatic hold(input logic [2:0] c, input int n);
    drive_code(c, n >= S);
    wait_cyc(n - 1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int rel;
    rst_n = 1'b0;
    {pin_r, pin_g, pin_b} = code_to_pins(3'd0);
    wait_cyc(3);
    n_checks++;
    if (color_idx !== 3'd0 || color_valid !== 1'b0 || change_pulse !== 1'b0 ||
        dwell_out !== 8'd0 || seq_err !== 1'b0 || dwell_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: idx=%0d valid=%0b pulse=%0b dwell=%0d seq=%0b derr=%0b, required all 0",
               color_idx, color_valid, change_pulse, dwell_out, seq_err, dwell_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    m_valid = 1'b0;
    model_code(3'd0, rel);
    wait_cyc(LAT - 1);
    n_checks++;
    if (color_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_early: color_valid=%0b at cycle %0d, required 0", color_valid, cyc);
    end
    wait_cyc(1);
    n_checks++;
    if (color_valid !== 1'b1 || color_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL first_qual: valid=%0b idx=%0d, required valid=1 idx=0", color_valid, color_idx);
    end
    wait_cyc(10);
  endtask

  task automatic test_cycle();
    for (int i = 1; i <= 6; i++) hold(3'(i % 6), 20);
    n_checks++;
    if (seq_err !== 1'b0 || dwell_err !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL cycle_flags: seq=%0b derr=%0b pending=%0d, required 0 0 0",
               seq_err, dwell_err, exp_q.size());
    end
  endtask

  task automatic test_glitch();
    hold(3'd1, 20);
    hold(3'd2, 20);
    hold(3'd4, 3);
    hold(3'd2, 20);
    n_checks++;
    if (color_idx !== 3'd2 || seq_err !== 1'b0 || dwell_err !== 1'b0) begin
      n_fail++;
      $display("FAIL short_glitch: idx=%0d seq=%0b derr=%0b, required 2 0 0",
               color_idx, seq_err, dwell_err);
    end
    hold(3'd4, 4);
    hold(3'd2, 20);
    n_checks++;
    if (color_idx !== 3'd2 || seq_err !== 1'b1 || dwell_err !== 1'b1) begin
      n_fail++;
      $display("FAIL long_glitch: idx=%0d seq=%0b derr=%0b, required 2 1 1",
               color_idx, seq_err, dwell_err);
    end
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    n_checks++;
    if (seq_err !== 1'b0 || dwell_err !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_err: seq=%0b derr=%0b, required 0 0", seq_err, dwell_err);
    end
  endtask

  task automatic test_dwell_err();
    hold(3'd3, 20);
    // blue: clear whatever the stretched cyan dwell flagged
    drive_code(3'd4, 1'b1);
    wait_cyc(10);
    clr_err = 1'b1;
    wait_cyc(1);
    clr_err = 1'b0;
    n_checks++;
    if (seq_err !== 1'b0 || dwell_err !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_mid: seq=%0b derr=%0b, required 0 0", seq_err, dwell_err);
    end
    wait_cyc(8);
    hold(3'd5, 30);
    drive_code(3'd0, 1'b1);
    wait_cyc(LAT + 1);
    n_checks++;
    if (dwell_out !== 8'd30 || dwell_err !== 1'b1 || seq_err !== 1'b0) begin
      n_fail++;
      $display("FAIL long_dwell: dwell=%0d derr=%0b seq=%0b, required 30 1 0",
               dwell_out, dwell_err, seq_err);
    end
    wait_cyc(25 - LAT - 2);
    // yellow after 25 cycles of red: new dwell error coincides with clr_err
    drive_code(3'd1, 1'b1);
    wait_cyc(LAT);
    clr_err = 1'b1;
    wait_cyc(1);
    clr_err = 1'b0;
    n_checks++;
    if (dwell_err !== 1'b1 || seq_err !== 1'b0 || dwell_out !== 8'd25) begin
      n_fail++;
      $display("FAIL set_wins: derr=%0b seq=%0b dwell=%0d, required 1 0 25",
               dwell_err, seq_err, dwell_out);
    end
    wait_cyc(20 - LAT - 2);
  endtask

  task automatic test_saturate();
    hold(3'd2, 300);
    drive_code(3'd3, 1'b1);
    wait_cyc(LAT + 1);
    n_checks++;
    if (dwell_out !== 8'hFF || dwell_err !== 1'b1 || color_idx !== 3'd3) begin
      n_fail++;
      $display("FAIL saturate: dwell=%0d derr=%0b idx=%0d, required 255 1 3",
               dwell_out, dwell_err, color_idx);
    end
    wait_cyc(30);
  endtask

  task automatic test_reset_mid();
    int rel;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (color_idx !== 3'd0 || color_valid !== 1'b0 || change_pulse !== 1'b0 ||
        dwell_out !== 8'd0 || seq_err !== 1'b0 || dwell_err !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: idx=%0d valid=%0b pulse=%0b dwell=%0d seq=%0b derr=%0b, required all 0",
               color_idx, color_valid, change_pulse, dwell_out, seq_err, dwell_err);
    end
    wait_cyc(3);
    rst_n = 1'b1;
    rel = cyc;
    m_valid = 1'b0;
    model_code(3'd3, rel);
    wait_cyc(25);
    n_checks++;
    if (color_valid !== 1'b1 || color_idx !== 3'd3 || seq_err !== 1'b0) begin
      n_fail++;
      $display("FAIL requal: valid=%0b idx=%0d seq=%0b, required 1 3 0",
               color_valid, color_idx, seq_err);
    end
    hold(3'd4, 20);
    n_checks++;
    if (dwell_err !== 1'b0 || seq_err !== 1'b0 || color_idx !== 3'd4) begin
      n_fail++;
      $display("FAIL post_reset_first: derr=%0b seq=%0b idx=%0d, required 0 0 4",
               dwell_err, seq_err, color_idx);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_cycle();
    test_glitch();
    test_dwell_err();
    test_saturate();
    test_reset_mid();
    wait_cyc(5);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_pulses: %0d expected pulses never seen, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
